// File: rtl/prog_loader_pkg.sv
// Shared constants, RX state encoding and timing helper for the UART program loader.
package prog_loader_pkg;

  localparam logic [31:0] PROG_TERMINATOR = 32'h0000_0FFF;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } rx_state_e;

  function automatic int unsigned clks_half(input int unsigned clks_per_bit);
    return clks_per_bit / 2;
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-FF synchroniser, mid-bit sampling FSM, byte and framing-error pulses.
module uart_rx_core
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic       rx_i,
  output logic       byte_valid_o,
  output logic [7:0] byte_data_o,
  output logic       frame_err_o
);

  localparam int unsigned    CntW     = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(clks_half(CLKS_PER_BIT) - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

  logic            r_rx_meta;
  logic            r_rx_sync;
  rx_state_e       r_state;
  logic [CntW-1:0] r_clk_cnt;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            w_stop_done;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
    end else begin
      r_rx_meta <= rx_i;
      r_rx_sync <= r_rx_meta;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= StIdle;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else if (!en_i) begin
      r_state   <= StIdle;
      r_clk_cnt <= '0;
      r_bit_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_clk_cnt <= '0;
          if (!r_rx_sync) r_state <= StStart;
        end
        StStart: begin
          if (r_clk_cnt == HalfLast) begin
            r_clk_cnt <= '0;
            r_bit_cnt <= '0;
            // A line already back high at mid-start-bit was only a glitch.
            r_state   <= r_rx_sync ? StIdle : StData;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StData: begin
          if (r_clk_cnt == BitLast) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_rx_sync, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 1'b1;
            if (r_bit_cnt == 3'd7) r_state <= StStop;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        StStop: begin
          if (r_clk_cnt == BitLast) begin
            r_clk_cnt <= '0;
            r_state   <= StIdle;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign w_stop_done  = en_i && (r_state == StStop) && (r_clk_cnt == BitLast);
  assign byte_valid_o = w_stop_done && r_rx_sync;
  assign frame_err_o  = w_stop_done && !r_rx_sync;
  assign byte_data_o  = r_shift;

endmodule

// File: rtl/uart_prog_loader.sv
// Packs received UART bytes little-endian into words and strobes them into instruction memory.
module uart_prog_loader
  import prog_loader_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned ADDR_W       = 13
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              rx_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [31:0]       wdata_o,
  output logic              done_o,
  output logic              frame_err_o
);

  logic              w_byte_valid;
  logic [7:0]        w_byte_data;
  logic              w_frame_err;
  logic [31:0]       w_word;

  logic [1:0]        r_byte_idx;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic              r_we;
  logic              r_done;
  logic              r_ferr;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .en_i        (en_i),
    .rx_i        (rx_i),
    .byte_valid_o(w_byte_valid),
    .byte_data_o (w_byte_data),
    .frame_err_o (w_frame_err)
  );

  assign w_word = {w_byte_data, r_wdata[23:0]};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_byte_idx <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
    end else if (!en_i) begin
      r_byte_idx <= '0;
      r_addr     <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_ferr     <= 1'b0;
    end else begin
      r_we <= 1'b0;
      // Address advances after the strobe so addr_o shows the written slot during we_o.
      if (r_we) r_addr <= r_addr + 1'b1;
      if (w_frame_err) r_ferr <= 1'b1;
      if (w_byte_valid && !r_done) begin
        r_byte_idx <= r_byte_idx + 1'b1;
        unique case (r_byte_idx)
          2'd0: r_wdata[7:0]   <= w_byte_data;
          2'd1: r_wdata[15:8]  <= w_byte_data;
          2'd2: r_wdata[23:16] <= w_byte_data;
          2'd3: begin
            r_wdata <= w_word;
            if (w_word == PROG_TERMINATOR) r_done <= 1'b1;
            else                           r_we   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign we_o        = r_we;
  assign addr_o      = r_addr;
  assign wdata_o     = r_wdata;
  assign done_o      = r_done;
  assign frame_err_o = r_ferr;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Scoreboard bench: stimulus queues expected writes, a monitor checks every we_o strobe.
module tb_uart_prog_loader;

  localparam int unsigned Cpb   = 8;
  localparam int unsigned AddrW = 4;

  logic             clk;
  logic             rst_ni;
  logic             en_i;
  logic             rx_i;
  logic             we_o;
  logic [AddrW-1:0] addr_o;
  logic [31:0]      wdata_o;
  logic             done_o;
  logic             frame_err_o;

  int n_cmp = 0;
  int n_err = 0;
  logic [AddrW+31:0] exp_q[$];

  uart_prog_loader #(
    .CLKS_PER_BIT(Cpb),
    .ADDR_W      (AddrW)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_ni),
    .en_i       (en_i),
    .rx_i       (rx_i),
    .we_o       (we_o),
    .addr_o     (addr_o),
    .wdata_o    (wdata_o),
    .done_o     (done_o),
    .frame_err_o(frame_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_ni && we_o) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_write: addr 0x%0h data 0x%08h, no write expected at %0t",
                 addr_o, wdata_o, $time);
      end else begin
        logic [AddrW+31:0] e;
        e = exp_q.pop_front();
        check("wr_addr", 32'(addr_o), 32'(e[AddrW+31:32]));
        check("wr_data", wdata_o, e[31:0]);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_time(input logic b);
    rx_i = b;
    repeat (Cpb) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(b[i]);
    bit_time(stop);
    rx_i = 1'b1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], 1'b1);
  endtask

  task automatic expect_write(input logic [AddrW-1:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic clear_en();
    rx_i = 1'b1;
    en_i = 1'b0;
    idle(3);
    en_i = 1'b1;
    idle(4);
  endtask

  task automatic check_q_empty(input string name);
    check(name, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    rst_ni = 1'b0;
    en_i   = 1'b1;
    rx_i   = 1'b1;
    idle(3);
    rst_ni = 1'b1;
    idle(2);
    check("rst_we", 32'(we_o), 32'd0);
    check("rst_addr", 32'(addr_o), 32'd0);
    check("rst_wdata", wdata_o, 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ferr", 32'(frame_err_o), 32'd0);

    // Single word
    expect_write(4'd0, 32'h0000_0513);
    send_word(32'h0000_0513);
    idle(10);
    check("single_addr_after", 32'(addr_o), 32'd1);
    check_q_empty("single_pending");

    // Terminator, then ignored bytes
    clear_en();
    for (int i = 0; i < 3; i++) begin
      expect_write(AddrW'(i), 32'h1111_0000 + 32'(i));
      send_word(32'h1111_0000 + 32'(i));
    end
    send_word(32'h0000_0FFF);
    idle(10);
    check("term_done", 32'(done_o), 32'd1);
    check("term_addr", 32'(addr_o), 32'd3);
    send_word(32'hDDCC_BBAA);
    idle(10);
    check("term_ignored_addr", 32'(addr_o), 32'd3);
    check("term_done_sticky", 32'(done_o), 32'd1);
    check_q_empty("term_pending");

    // Framing error then a good word
    clear_en();
    check("en_clears_done", 32'(done_o), 32'd0);
    send_byte(8'h12, 1'b0);
    idle(2 * Cpb);
    check("ferr_set", 32'(frame_err_o), 32'd1);
    check("ferr_no_addr_move", 32'(addr_o), 32'd0);
    expect_write(4'd0, 32'h1234_5678);
    send_word(32'h1234_5678);
    idle(10);
    check("ferr_sticky", 32'(frame_err_o), 32'd1);
    check("ferr_addr_after", 32'(addr_o), 32'd1);
    check_q_empty("ferr_pending");

    // Glitch
    clear_en();
    rx_i = 1'b0;
    idle(2);
    rx_i = 1'b1;
    idle(20);
    check("glitch_no_ferr", 32'(frame_err_o), 32'd0);
    check("glitch_no_addr", 32'(addr_o), 32'd0);
    expect_write(4'd0, 32'hCAFE_0001);
    send_word(32'hCAFE_0001);
    idle(10);
    check("glitch_addr_after", 32'(addr_o), 32'd1);
    check_q_empty("glitch_pending");

    // Address wrap over 17 words
    clear_en();
    for (int i = 0; i < 17; i++) begin
      expect_write(AddrW'(i), 32'hA000_0000 + 32'(i));
      send_word(32'hA000_0000 + 32'(i));
    end
    idle(10);
    check("wrap_addr_after", 32'(addr_o), 32'd1);
    check_q_empty("wrap_pending");

    // Reset during DATA of byte 2
    clear_en();
    send_byte(8'h01, 1'b1);
    send_byte(8'h02, 1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    bit_time(1'b0);
    rst_ni = 1'b0;
    #1;
    check("mrst_we", 32'(we_o), 32'd0);
    check("mrst_addr", 32'(addr_o), 32'd0);
    check("mrst_wdata", wdata_o, 32'd0);
    check("mrst_done", 32'(done_o), 32'd0);
    check("mrst_ferr", 32'(frame_err_o), 32'd0);
    rx_i = 1'b1;
    idle(2);
    rst_ni = 1'b1;
    idle(20);
    expect_write(4'd0, 32'h0BAD_F00D);
    send_word(32'h0BAD_F00D);
    idle(10);
    check("mrst_addr_after", 32'(addr_o), 32'd1);
    check_q_empty("mrst_pending");

    // Enable drop during DATA of byte 2, with both sticky flags set first
    send_byte(8'h55, 1'b0);
    idle(2 * Cpb);
    send_word(32'h0000_0FFF);
    idle(10);
    check("pre_en_ferr", 32'(frame_err_o), 32'd1);
    check("pre_en_done", 32'(done_o), 32'd1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h04, 1'b1);
    bit_time(1'b0);
    bit_time(1'b1);
    rx_i = 1'b1;
    en_i = 1'b0;
    idle(3);
    check("en_we", 32'(we_o), 32'd0);
    check("en_addr", 32'(addr_o), 32'd0);
    check("en_done", 32'(done_o), 32'd0);
    check("en_ferr", 32'(frame_err_o), 32'd0);
    en_i = 1'b1;
    idle(20);
    expect_write(4'd0, 32'h8765_4321);
    send_word(32'h8765_4321);
    idle(10);
    check("en_addr_after", 32'(addr_o), 32'd1);
    check_q_empty("en_pending");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
